// File: rtl/order_tx_scheduler.sv
// order_tx_scheduler
//   Round-robin arbiter across NUM_REQ strategy requesters. It applies a token-bucket
//   rate limit and sends each accepted order as two 64-bit TX beats: a header, then
//   the price, over a valid/ready handshake.
//   Optional build macro ORDER_TS_EN: when defined, a free-running 32-bit cycle
//   counter is captured at grant time and placed in header bits [31:0].
module order_tx_scheduler #(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned TOKEN_MAX     = 8,
   parameter int unsigned REFILL_PERIOD = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           enable,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*64-1:0]          req_price,
   input  logic [NUM_REQ-1:0]             req_side,
   output logic [NUM_REQ-1:0]             grant,
   output logic [63:0]                    tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic [$clog2(TOKEN_MAX+1)-1:0] tokens,
   output logic [31:0]                    orders_sent,
   output logic [31:0]                    throttle_cycles,
   output logic                           busy
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TW = $clog2(TOKEN_MAX + 1);
   localparam int unsigned CW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      PRICE = 2'd2
   } state_t;

   state_t              state_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic [63:0]         tx_data_q;
   logic                tx_valid_q;
   logic [63:0]         price_q;
   logic [IW-1:0]       ptr_q;
   logic [IW-1:0]       ptr_d;
   logic [7:0]          seq_q;
   logic [31:0]         orders_q;
   logic [31:0]         throttle_q;
   logic [TW-1:0]       tokens_q;
   logic [TW-1:0]       tokens_d;
   logic [CW-1:0]       refill_cnt_q;
   logic [CW-1:0]       refill_cnt_d;

   logic [IW:0]         cand;
   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic                grant_go;
   logic                throttle_hit;
   logic                refill_tick;
   logic [63:0]         hdr_d;
   logic [31:0]         ts_field;

`ifdef ORDER_TS_EN
   logic [31:0]         ts_q;

   // Free-running cycle stamp, sampled into the header at grant time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_q <= '0;
      else        ts_q <= ts_q + 32'd1;
   end

   assign ts_field = ts_q;
`else
   assign ts_field = '0;
`endif

   // Round-robin search: first asserted request at or after the pointer, with wrap-around
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
         if (!pick_found && req[cand[IW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IW-1:0];
         end
      end
   end

   // Grant, throttle and refill qualifiers, plus the header formed at grant time
   always_comb begin
      grant_go     = (state_q == IDLE) && enable && pick_found && (tokens_q != '0);
      throttle_hit = (state_q == IDLE) && enable && (|req) && (tokens_q == '0);
      refill_tick  = (refill_cnt_q == CW'(REFILL_PERIOD - 1));
      ptr_d        = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
      hdr_d        = {8'hA5, seq_q, 8'(pick_idx), req_side[pick_idx], 7'b0, ts_field};
   end

   // Token bucket next state: a refill and a consume in the same cycle cancel out
   always_comb begin
      tokens_d     = tokens_q;
      refill_cnt_d = refill_tick ? '0 : refill_cnt_q + CW'(1);
      if (grant_go && !refill_tick)
         tokens_d = tokens_q - TW'(1);
      else if (refill_tick && !grant_go && (tokens_q != TW'(TOKEN_MAX)))
         tokens_d = tokens_q + TW'(1);
   end

   // Token bucket, refill timer and throttle counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tokens_q     <= TW'(TOKEN_MAX);
         refill_cnt_q <= '0;
         throttle_q   <= '0;
      end else begin
         tokens_q     <= tokens_d;
         refill_cnt_q <= refill_cnt_d;
         if (throttle_hit && (throttle_q != '1))
            throttle_q <= throttle_q + 32'd1;
      end
   end

   // Order FSM: grant in IDLE, then header and price beats, with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         price_q    <= '0;
         ptr_q      <= '0;
         seq_q      <= '0;
         orders_q   <= '0;
      end else begin
         grant_q <= '0;
         case (state_q)
            IDLE: begin
               if (grant_go) begin
                  grant_q    <= NUM_REQ'(1) << pick_idx;
                  price_q    <= req_price[64*pick_idx +: 64];
                  ptr_q      <= ptr_d;
                  tx_data_q  <= hdr_d;
                  tx_valid_q <= 1'b1;
                  state_q    <= HDR;
               end
            end
            HDR: begin
               if (tx_ready) begin
                  tx_data_q <= price_q;
                  state_q   <= PRICE;
               end
            end
            PRICE: begin
               if (tx_ready) begin
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= '0;
                  orders_q   <= orders_q + 32'd1;
                  seq_q      <= seq_q + 8'd1;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant           = grant_q;
   assign tx_data         = tx_data_q;
   assign tx_valid        = tx_valid_q;
   assign tokens          = tokens_q;
   assign orders_sent     = orders_q;
   assign throttle_cycles = throttle_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_order_tx_scheduler.sv
// Testbench for order_tx_scheduler. A transaction-level reference model keeps the
// pending TX words in a queue, tracks the token level arithmetically from the cycle
// count, and applies the round-robin rule directly to the request vector.
module tb_order_tx_scheduler;

   localparam int NREQ = 4;
   localparam int TMAX = 8;
   localparam int P    = 40;

   logic                 clk;
   logic                 rst_n;
   logic                 enable;
   logic [NREQ-1:0]      req;
   logic [NREQ*64-1:0]   req_price;
   logic [NREQ-1:0]      req_side;
   logic [NREQ-1:0]      grant;
   logic [63:0]          tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [3:0]           tokens;
   logic [31:0]          orders_sent;
   logic [31:0]          throttle_cycles;
   logic                 busy;

   order_tx_scheduler #(
      .NUM_REQ(NREQ),
      .TOKEN_MAX(TMAX),
      .REFILL_PERIOD(P)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .req(req),
      .req_price(req_price),
      .req_side(req_side),
      .grant(grant),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tokens(tokens),
      .orders_sent(orders_sent),
      .throttle_cycles(throttle_cycles),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [63:0]     m_q[$];
   int              m_tok;
   int              m_ptr;
   int              m_n;
   int              last_gi;
   logic [31:0]     m_orders;
   logic [31:0]     m_thr;
   logic [NREQ-1:0] exp_grant;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_tok     = TMAX;
      m_ptr     = 0;
      m_n       = 0;
      last_gi   = -1;
      m_orders  = '0;
      m_thr     = '0;
      exp_grant = '0;
   endtask

   // Expected effect of the coming clock edge, given the inputs now driven
   task automatic model_edge();
      int          gi;
      bit          refill;
      logic [63:0] hdr;
      gi = -1;
      if (m_q.size() != 0) begin
         if (tx_ready) begin
            if (m_q.size() == 1) m_orders = m_orders + 32'd1;
            void'(m_q.pop_front());
         end
      end else if (enable && (req != '0)) begin
         if (m_tok > 0) begin
            for (int k = 0; k < NREQ; k++)
               if (gi < 0 && req[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
         end else if (m_thr != 32'hFFFF_FFFF) begin
            m_thr = m_thr + 32'd1;
         end
      end
      refill = ((m_n % P) == P - 1);
      m_tok  = m_tok + (refill ? 1 : 0) - ((gi >= 0) ? 1 : 0);
      if (m_tok > TMAX) m_tok = TMAX;
      if (gi >= 0) begin
         m_ptr = (gi + 1) % NREQ;
         hdr = {8'hA5, m_orders[7:0], 8'(gi), req_side[gi], 39'd0};
`ifdef ORDER_TS_EN
         hdr[31:0] = 32'(m_n);
`endif
         m_q.push_back(hdr);
         m_q.push_back(req_price[gi*64 +: 64]);
         exp_grant = NREQ'(1) << gi;
      end else begin
         exp_grant = '0;
      end
      last_gi = gi;
      m_n++;
   endtask

   task automatic compare_all();
      check("grant", 64'(grant), 64'(exp_grant));
      check("tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
      check("busy", 64'(busy), 64'(m_q.size() != 0));
      if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
      check("tokens", 64'(tokens), 64'(m_tok));
      check("orders_sent", 64'(orders_sent), 64'(m_orders));
      check("throttle", 64'(throttle_cycles), 64'(m_thr));
   endtask

   // One clock: model the edge, let it happen, compare on the falling edge
   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      enable    = 1'b0;
      req       = '0;
      req_side  = '0;
      req_price = '0;
      tx_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_valid", 64'(tx_valid), 64'd0);
      check("rst_data", tx_data, 64'd0);
      check("rst_tokens", 64'(tokens), 64'(TMAX));
      check("rst_orders", 64'(orders_sent), 64'd0);
      check("rst_throttle", 64'(throttle_cycles), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int g;
      int last_c;
      bit saw0;
      bit pend [NREQ];

      rst_n = 1'b0;
      model_reset();

      // Single request
      do_reset();
      enable    = 1'b1;
      tx_ready  = 1'b1;
      req       = 4'b0100;
      req_side  = 4'b0100;
      req_price[2*64 +: 64] = 64'h0000_0000_0098_9680;
      cycle();
      check("t1_grant", 64'(grant), 64'h4);
      check("t1_hdr", tx_data, 64'hA500_0280_0000_0000);
      req = '0;
      cycle();
      check("t1_price", tx_data, 64'h0000_0000_0098_9680);
      cycle();
      check("t1_orders", 64'(orders_sent), 64'd1);
      check("t1_tokens", 64'(tokens), 64'd7);

      // Round-robin with all requests held
      do_reset();
      enable   = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) req_price[i*64 +: 64] = 64'h1000 + 64'(i);
      req_side = 4'b1010;
      req      = 4'b1111;
      g = 0;
      last_c = 0;
      for (int c = 0; c < 15; c++) begin
         cycle();
         if (grant != '0) begin
            check("rr_order", 64'(grant), 64'(4'b0001 << (g % 4)));
            if (g > 0) check("rr_spacing", 64'(c - last_c), 64'd3);
            last_c = c;
            g++;
         end
      end
      check("rr_count", 64'(g), 64'd5);

      // Throttle: ninth order waits for the first refill
      do_reset();
      enable   = 1'b1;
      tx_ready = 1'b1;
      req      = 4'b1111;
      g = 0;
      saw0 = 1'b0;
      for (int c = 0; c < 200 && g < 9; c++) begin
         cycle();
         if (tokens == '0) saw0 = 1'b1;
         if (grant != '0) begin
            g++;
            if (g == 9) begin
               check("thr_edge_9th", 64'(c), 64'(P));
               check("thr_count", 64'(throttle_cycles), 64'(P - 24));
            end
         end
      end
      check("thr_grants", 64'(g), 64'd9);
      check("thr_saw_zero", 64'(saw0), 64'd1);

      // Backpressure during both beats
      do_reset();
      enable   = 1'b1;
      tx_ready = 1'b0;
      req      = 4'b0001;
      req_price[63:0] = 64'hDEAD_BEEF_0123_4567;
      cycle();
      req = '0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_hdr_hold", tx_data, 64'hA500_0000_0000_0000);
      end
      tx_ready = 1'b1;
      cycle();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("bp_price_hold", tx_data, 64'hDEAD_BEEF_0123_4567);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      check("bp_orders", 64'(orders_sent), 64'd1);

      // Refill coincident with a grant at tokens == 3
      do_reset();
      enable   = 1'b1;
      tx_ready = 1'b1;
      req      = 4'b0001;
      req_price[127:64] = 64'h0000_0000_0000_7777;
      g = 0;
      for (int c = 0; c < 40 && g < 5; c++) begin
         cycle();
         if (grant != '0) g++;
         if (g == 5) req = '0;
      end
      while (m_n < P) begin
         req = (m_n == P - 1) ? 4'b0010 : 4'b0000;
         cycle();
      end
      check("t5_grant", 64'(grant), 64'h2);
      check("t5_tokens", 64'(tokens), 64'd3);
      req = '0;

      // Reset during the price beat
      do_reset();
      enable   = 1'b1;
      tx_ready = 1'b1;
      req      = 4'b0100;
      cycle();
      req = '0;
      cycle();
      check("t6_in_price", 64'(tx_valid), 64'd1);
      tx_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", 64'(tx_valid), 64'd0);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_tokens", 64'(tokens), 64'(TMAX));
      check("t6_orders", 64'(orders_sent), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Randomized traffic long enough to wrap the 8-bit sequence number
      do_reset();
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
      for (int c = 0; c < 12000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (last_gi == i) begin
               pend[i] = 1'b0;
            end else if (pend[i]) begin
               if ($urandom_range(0, 63) == 0) pend[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               req_price[i*64 +: 64] = {$urandom, $urandom};
               req_side[i] = $urandom_range(0, 1) == 1;
            end
            req[i] = pend[i];
         end
         enable   = ($urandom_range(0, 19) != 0);
         tx_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      check("rand_seq_wrap", 64'(orders_sent > 32'd256), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
